// File: rtl/data_cache.sv
// Set-associative (1 or 2 way), write-through, no-write-allocate data cache with
// combinational hit path, single-word lines and read hit/miss counters.
module data_cache #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32,
    parameter int SETS          = 8,
    parameter int WAYS          = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req,
    input  logic                     we,
    input  logic [ADDRESS_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0]    wd,
    input  logic                     flush,
    output logic [DATA_WIDTH-1:0]    rd,
    output logic                     stall,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]    mem_wd,
    input  logic [DATA_WIDTH-1:0]    mem_rd,
    input  logic                     mem_ready,
    output logic [31:0]              hit_count,
    output logic [31:0]              miss_count
);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDRESS_WIDTH - 2 - IDX_W;
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    genvar gi;

    if (WAYS != 1 && WAYS != 2) begin : g_bad_ways
        $error("data_cache: WAYS must be 1 or 2");
    end

    typedef enum logic [1:0] {IDLE, READ_MISS, WRITE, DONE} state_t;

    state_t                  state_q, state_d;
    logic [WAYS-1:0]         valid_q [SETS];
    logic [SETS-1:0]         lru_q;
    logic [TAG_W-1:0]        tag_q   [SETS][WAYS];
    logic [DATA_WIDTH-1:0]   data_q  [SETS][WAYS];
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic [31:0]             hit_q, miss_q;

    logic [IDX_W-1:0]        index;
    logic [TAG_W-1:0]        tag;
    logic [WAYS-1:0]         hit_vec;
    logic                    hit;
    logic [WAY_W-1:0]        hit_way;
    logic [WAY_W-1:0]        victim;
    logic [DATA_WIDTH-1:0]   hit_data;
    logic                    do_hit, do_miss, do_flush, do_fill, do_wr_upd;
    logic                    unused_addr_lsb;

    assign index           = addr[2 +: IDX_W];
    assign tag             = addr[ADDRESS_WIDTH-1 -: TAG_W];
    assign unused_addr_lsb = ^addr[1:0];

    for (gi = 0; gi < WAYS; gi++) begin : g_way
        assign hit_vec[gi] = valid_q[index][gi] && (tag_q[index][gi] == tag);
    end

    assign hit = |hit_vec;

    always_comb begin
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (hit_vec[w]) hit_way = WAY_W'(w);
        end
    end

    assign hit_data = data_q[index][hit_way];

    // Fill an invalid way first (way 0 preferred); only fall back to LRU when the set is full.
    always_comb begin
        victim = '0;
        if (WAYS == 2) begin
            if (!valid_q[index][0])           victim = '0;
            else if (!valid_q[index][WAYS-1]) victim = WAY_W'(1);
            else                              victim = WAY_W'(lru_q[index]);
        end
    end

    function automatic logic lru_after(input logic [WAY_W-1:0] used_way);
        return (WAYS == 2) ? ~used_way[0] : 1'b0;
    endfunction

    always_comb begin
        state_d   = state_q;
        stall     = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        rd        = '0;
        do_hit    = 1'b0;
        do_miss   = 1'b0;
        do_flush  = 1'b0;
        do_fill   = 1'b0;
        do_wr_upd = 1'b0;
        case (state_q)
            IDLE: begin
                if (flush) begin
                    do_flush = 1'b1;
                    stall    = req;
                end else if (req) begin
                    if (we) begin
                        stall   = 1'b1;
                        state_d = WRITE;
                    end else if (hit) begin
                        rd     = hit_data;
                        do_hit = 1'b1;
                    end else begin
                        stall   = 1'b1;
                        do_miss = 1'b1;
                        state_d = READ_MISS;
                    end
                end
            end
            READ_MISS: begin
                stall   = 1'b1;
                mem_req = 1'b1;
                if (mem_ready) begin
                    do_fill = 1'b1;
                    state_d = DONE;
                end
            end
            WRITE: begin
                stall   = 1'b1;
                mem_req = 1'b1;
                mem_we  = 1'b1;
                if (mem_ready) begin
                    do_wr_upd = hit;
                    state_d   = DONE;
                end
            end
            DONE: begin
                rd      = rdata_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            lru_q   <= '0;
            rdata_q <= '0;
            hit_q   <= '0;
            miss_q  <= '0;
            for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
        end else begin
            state_q <= state_d;
            if (do_hit)  hit_q  <= hit_q + 32'd1;
            if (do_miss) miss_q <= miss_q + 32'd1;
            if (do_flush) begin
                for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
            end
            if (do_fill) begin
                valid_q[index][victim] <= 1'b1;
                lru_q[index]           <= lru_after(victim);
                rdata_q                <= mem_rd;
            end
            if (do_hit || do_wr_upd) lru_q[index] <= lru_after(hit_way);
        end
    end

    // Tag/data arrays carry no reset; a reset cycle only blocks writes so an abandoned fill is dropped.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (do_fill) begin
                tag_q[index][victim]  <= tag;
                data_q[index][victim] <= mem_rd;
            end
            if (do_wr_upd) data_q[index][hit_way] <= wd;
        end
    end

    assign mem_addr   = {addr[ADDRESS_WIDTH-1:2], 2'b00};
    assign mem_wd     = wd;
    assign hit_count  = hit_q;
    assign miss_count = miss_q;

endmodule
